axis_pwm_core: RTL and testbench

Converts an AXI-Stream sample stream into a pulse-width-modulated output in the clkA domain. Each accepted sample sets the duty of one PWM period. The block emits a one-clock `period_tick` at the end of every period. That tick is the pulse source driven into the clkA→clkB flag crossing stage, which relays the period boundary to the clkB-side sample requester. A one-entry holding register decouples stream arrival from period boundaries.

---
 rtl/axis_pwm_core.sv | 113 +++++++++++
 tb/tb_axis_pwm_core.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axis_pwm_core.sv
// axis_pwm_core: turns a stream of AXI-Stream duty samples into a PWM output in the clkA domain.
// A one-entry holding register decouples sample arrival from period boundaries.
module axis_pwm_core #(
  parameter int CNT_W      = 16,
  parameter int MIN_PERIOD = 4
) (
  input  logic             clkA,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic             pwm_out,
  output logic             period_tick,
  output logic             underrun,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} stateT;

  localparam logic [CNT_W-1:0] MinPe = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] duty, dutyNext;
  logic [CNT_W-1:0] pe, peNext;
  logic [CNT_W-1:0] holdData, holdDataNext;
  logic             holdFull, holdFullNext;
  logic [CNT_W-1:0] cfgPe;
  logic             handshake, wrap, runningNext;

  assign cfgPe       = (cfg_period < MinPe) ? MinPe : cfg_period;
  assign handshake   = s_axis_tvalid & s_axis_tready;
  assign wrap        = (cnt == pe - One);
  assign runningNext = (stateNext != IDLE);

  // Underrun must see a sample arriving in the wrap cycle itself, so it is the one live-gated output.
  assign underrun = period_tick & ~holdFull & ~handshake;

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    dutyNext     = duty;
    peNext       = pe;
    holdFullNext = holdFull;
    holdDataNext = holdData;

    if (handshake) begin
      holdFullNext = 1'b1;
      holdDataNext = s_axis_tdata;
    end

    unique case (state)
      IDLE: begin
        cntNext = '0;
        if (enable) begin
          stateNext = RUN;
          peNext    = cfgPe;
          dutyNext  = holdFull ? holdData : '0;
          if (holdFull) holdFullNext = 1'b0;
        end
      end
      RUN, STOPPING: begin
        if (wrap) begin
          cntNext   = '0;
          peNext    = cfgPe;
          stateNext = enable ? RUN : IDLE;
          // An empty register with a sample arriving right now bypasses straight into the duty.
          if (holdFull) begin
            dutyNext     = holdData;
            holdFullNext = 1'b0;
          end else if (handshake) begin
            dutyNext     = s_axis_tdata;
            holdFullNext = 1'b0;
          end
        end else begin
          cntNext = cnt + One;
          if (state == RUN && !enable) stateNext = STOPPING;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkA) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      duty          <= '0;
      pe            <= '0;
      holdFull      <= 1'b0;
      holdData      <= '0;
      s_axis_tready <= 1'b0;
      pwm_out       <= 1'b0;
      period_tick   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      duty          <= dutyNext;
      pe            <= peNext;
      holdFull      <= holdFullNext;
      holdData      <= holdDataNext;
      s_axis_tready <= ~holdFullNext;
      pwm_out       <= runningNext && (cntNext < dutyNext);
      period_tick   <= runningNext && (cntNext == peNext - One);
      busy          <= runningNext;
    end
  end

endmodule

// File: tb/tb_axis_pwm_core.sv
// tb_axis_pwm_core: directed vectors and hand-written sequences for axis_pwm_core.
// Each step drives one cycle's inputs just after the clock edge and checks that cycle's outputs.
module tb_axis_pwm_core;

  typedef struct {
    logic        en;
    logic [15:0] cfg;
    logic        tv;
    logic [15:0] td;
    logic        pwm;
    logic        tick;
    logic        und;
    logic        busy;
    logic        rdy;
  } vecT;

  logic        clkA = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] cfgPeriod = 16'd0;
  logic [15:0] tdata = 16'd0;
  logic        tvalid = 1'b0;
  logic        tready, pwmOut, periodTick, underrun, busy;

  int errors = 0;
  int checks = 0;
  vecT vecs[14];

  axis_pwm_core #(.CNT_W(16), .MIN_PERIOD(4)) dut (
    .clkA(clkA),
    .rst(rst),
    .enable(enable),
    .cfg_period(cfgPeriod),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .pwm_out(pwmOut),
    .period_tick(periodTick),
    .underrun(underrun),
    .busy(busy)
  );

  always #5 clkA = ~clkA;

  task automatic applyStimulus(input logic en, input logic [15:0] cfg,
                               input logic tv, input logic [15:0] td);
    @(posedge clkA);
    #1;
    enable    = en;
    cfgPeriod = cfg;
    tvalid    = tv;
    tdata     = td;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic ePwm, input logic eTick,
                            input logic eUnd, input logic eBusy, input logic eRdy);
    checkOutput({tag, " pwm_out"}, pwmOut, ePwm);
    checkOutput({tag, " period_tick"}, periodTick, eTick);
    checkOutput({tag, " underrun"}, underrun, eUnd);
    checkOutput({tag, " busy"}, busy, eBusy);
    checkOutput({tag, " tready"}, tready, eRdy);
  endtask

  initial begin
    logic [15:0] dutyA[3];
    logic [15:0] dutyB[4];
    logic        en, tv, eRdy;
    logic [15:0] td;

    // cfg_period=2 is raised to Pe=4; no samples, so every tick is an underrun
    vecs[0]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 16'd2, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 16'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset: everything low, then tready rises in the first cycle after release
    applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
    checkCycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 16'd10, 1'b1, 16'd3);
    checkCycle("postReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd10, 1'b1, 16'd7);
    checkCycle("idleHeld", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Duties 3, 7, 5 at Pe=10; enable drops at cnt=4 of the last period
    dutyA = '{16'd3, 16'd7, 16'd5};
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 10; c++) begin
        en   = !(p == 2 && c >= 4);
        tv   = (c == 0 && p < 2);
        td   = (p == 0) ? 16'd7 : 16'd5;
        eRdy = (p == 2) || (c == 0);
        applyStimulus(en, 16'd10, tv, td);
        checkCycle($sformatf("seqA p%0d c%0d", p, c), (16'(c) < dutyA[p]),
                   (c == 9), (p == 2 && c == 9), 1'b1, eRdy);
      end
    end
    applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
    checkCycle("seqA idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].cfg, vecs[i].tv, vecs[i].td);
      checkCycle($sformatf("vec%0d", i), vecs[i].pwm, vecs[i].tick, vecs[i].und,
                 vecs[i].busy, vecs[i].rdy);
    end

    // Duty 0, duty 15 (>= Pe), an underrun that keeps 15, then a wrap-cycle bypass of 2
    applyStimulus(1'b0, 16'd10, 1'b1, 16'd0);
    checkCycle("seqB load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd10, 1'b0, 16'd0);
    checkCycle("seqB held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    dutyB = '{16'd0, 16'd15, 16'd15, 16'd2};
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 10; c++) begin
        en   = (p != 3);
        tv   = (p == 0 && c == 0) || (p == 2 && c == 9);
        td   = (p == 0) ? 16'd15 : 16'd2;
        eRdy = (p != 0) || (c == 0);
        applyStimulus(en, 16'd10, tv, td);
        checkCycle($sformatf("seqB p%0d c%0d", p, c), (16'(c) < dutyB[p]),
                   (c == 9), ((p == 1 || p == 3) && c == 9), 1'b1, eRdy);
      end
    end
    applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
    checkCycle("seqB idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset at cnt=6 with a held sample: abort, no tick, sample dropped
    applyStimulus(1'b0, 16'd10, 1'b1, 16'd8);
    checkCycle("seqC load", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd10, 1'b0, 16'd0);
    checkCycle("seqC held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b1, 16'd10, (c == 0), 16'd4);
      checkCycle($sformatf("seqC c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, (c == 0));
    end
    rst = 1'b0;
    applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
    checkCycle("seqC inReset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 16'd10, 1'b0, 16'd0);
    checkCycle("seqC released", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
      checkCycle($sformatf("seqC after c%0d", c), 1'b0, (c == 9), (c == 9), 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 16'd10, 1'b0, 16'd0);
    checkCycle("seqC idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
